// File: rtl/tmds_channel_ctrl.sv
// +--------------------------------------------------------------------+
// | tmds_channel_ctrl: one TMDS lane with control/preamble/guard/video |
// | sequencing and DC-balancing disparity tracking.     Revision: 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

module tmds_stage1 (
  input  logic [7:0] data,
  output logic [8:0] q_m
);
  logic [3:0] ones;
  logic       use_xnor;
  logic       acc;

  always_comb begin
    ones = '0;
    for (int i = 0; i < 8; i++) ones = ones + {3'b000, data[i]};
    use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !data[0]);
    acc      = data[0];
    q_m      = '0;
    q_m[0]   = acc;
    for (int i = 1; i < 8; i++) begin
      acc    = use_xnor ? ~(acc ^ data[i]) : (acc ^ data[i]);
      q_m[i] = acc;
    end
    q_m[8] = ~use_xnor;
  end
endmodule

module tmds_channel_ctrl #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vid_valid,
  input  logic [7:0] vid_data,
  output logic       vid_ready,
  input  logic [1:0] ctrl,
  output logic [9:0] tmds_word,
  output logic       tmds_valid
);
  localparam logic [9:0] C_GUARD_WORD = 10'b1011001100;
  localparam logic [9:0] C_TOKEN_00   = 10'b1101010100;

  typedef enum logic [1:0] {S_CTRL, S_PRE, S_GUARD, S_VIDEO} state_t;

  state_t             state;
  logic [3:0]         pre_cnt;
  logic [1:0]         guard_cnt;
  logic signed [4:0]  cnt;

  logic [8:0]         q_m;
  logic [3:0]         n1;
  logic [3:0]         n0;
  logic signed [4:0]  diff;
  logic [9:0]         enc_word;
  logic signed [4:0]  cnt_next;

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    case (c)
      2'b00:   ctrl_token = 10'b1101010100;
      2'b01:   ctrl_token = 10'b0010101011;
      2'b10:   ctrl_token = 10'b0101010100;
      default: ctrl_token = 10'b1010101011;
    endcase
  endfunction

  tmds_stage1 u_stage1 (
    .data (vid_data),
    .q_m  (q_m)
  );

  // diff = N1 - N0 of the stage-one output, range -8..+8
  always_comb begin
    n1 = '0;
    for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, q_m[i]};
    n0   = 4'd8 - n1;
    diff = $signed({1'b0, n1}) - $signed({1'b0, n0});

    if ((cnt == 5'sd0) || (diff == 5'sd0)) begin
      enc_word = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      cnt_next = q_m[8] ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > 5'sd0) && (diff > 5'sd0)) || ((cnt < 5'sd0) && (diff < 5'sd0))) begin
      enc_word = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_next = cnt + (q_m[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      enc_word = {1'b0, q_m[8], q_m[7:0]};
      cnt_next = cnt + diff - (q_m[8] ? 5'sd0 : 5'sd2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_CTRL;
      pre_cnt    <= '0;
      guard_cnt  <= '0;
      cnt        <= '0;
      tmds_word  <= C_TOKEN_00;
      tmds_valid <= 1'b0;
      vid_ready  <= 1'b0;
    end else begin
      tmds_valid <= 1'b1;
      case (state)
        S_CTRL: begin
          tmds_word <= ctrl_token(ctrl);
          if (vid_valid) state <= S_PRE;
        end
        S_PRE: begin
          tmds_word <= ctrl_token(ctrl);
          if (!vid_valid) begin
            state   <= S_CTRL;
            pre_cnt <= '0;
          end else if (pre_cnt == 4'(PREAMBLE_LEN - 1)) begin
            state   <= S_GUARD;
            pre_cnt <= '0;
          end else begin
            pre_cnt <= pre_cnt + 4'd1;
          end
        end
        S_GUARD: begin
          tmds_word <= C_GUARD_WORD;
          if (guard_cnt == 2'(GUARD_LEN - 1)) begin
            state     <= S_VIDEO;
            guard_cnt <= '0;
            vid_ready <= 1'b1;
          end else begin
            guard_cnt <= guard_cnt + 2'd1;
          end
        end
        default: begin
          if (vid_valid) begin
            tmds_word <= enc_word;
            cnt       <= cnt_next;
          end else begin
            tmds_word <= ctrl_token(ctrl);
            state     <= S_CTRL;
            cnt       <= '0;
            vid_ready <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_tmds_channel_ctrl.sv
// Bench for tmds_channel_ctrl: scoreboard of expected symbols from an
// independent encoder model, plus directed sequencing checks.
`default_nettype none

module tb_tmds_channel_ctrl;
  localparam logic [9:0] GUARD_W = 10'b1011001100;

  logic       clk = 1'b0;
  logic       rst;
  logic       vid_valid;
  logic [7:0] vid_data;
  logic       vid_ready;
  logic [1:0] ctrl;
  logic [9:0] tmds_word;
  logic       tmds_valid;

  int         n_cmp = 0;
  int         n_err = 0;
  int         disp  = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  tmds_channel_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .vid_valid  (vid_valid),
    .vid_data   (vid_data),
    .vid_ready  (vid_ready),
    .ctrl       (ctrl),
    .tmds_word  (tmds_word),
    .tmds_valid (tmds_valid)
  );

  function automatic logic [9:0] tok(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = 10'b1101010100;
      2'b01:   t = 10'b0010101011;
      2'b10:   t = 10'b0101010100;
      default: t = 10'b1010101011;
    endcase
    return t;
  endfunction

  // Reference encoder; advances the bench's own disparity count.
  function automatic logic [9:0] model_enc(input logic [7:0] d);
    int         n1;
    int         m1;
    int         m0;
    logic       x;
    logic [8:0] q;
    logic [9:0] w;
    n1   = $countones(d);
    x    = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = x ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !x;
    m1 = $countones(q[7:0]);
    m0 = 8 - m1;
    if (disp == 0 || m1 == m0) begin
      w = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      disp += q[8] ? (m1 - m0) : (m0 - m1);
    end else if ((disp > 0 && m1 > m0) || (disp < 0 && m0 > m1)) begin
      w = {1'b1, q[8], ~q[7:0]};
      disp += (q[8] ? 2 : 0) + m0 - m1;
    end else begin
      w = {1'b0, q[8], q[7:0]};
      disp += m1 - m0 - (q[8] ? 0 : 2);
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    vid_data  = b;
    vid_valid = 1'b1;
    exp_q.push_back(model_enc(b));
    tick();
  endtask

  // From CTRL with vid_valid held: CTRL + PREAMBLE tokens, guard band, then ready.
  task automatic enter_video(input logic [1:0] c, input string tag);
    logic [9:0] ew;
    logic       er;
    ctrl      = c;
    vid_valid = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      ew = (k <= 9) ? tok(c) : GUARD_W;
      er = (k == 11);
      n_cmp++;
      if (tmds_word !== ew || vid_ready !== er) begin
        n_err++;
        $display("FAIL %s cycle %0d: word=%b ready=%b, required word=%b ready=%b",
                 tag, k, tmds_word, vid_ready, ew, er);
      end
    end
    disp = disp;
  endtask

  task automatic test_reset();
    rst = 1'b1; vid_valid = 1'b0; vid_data = 8'h00; ctrl = 2'b00;
    tick();
    tick();
    n_cmp++;
    if (tmds_word !== 10'b1101010100 || tmds_valid !== 1'b0 || vid_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: word=%b valid=%b ready=%b, required 1101010100/0/0",
               tmds_word, tmds_valid, vid_ready);
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (tmds_word !== 10'b1101010100 || tmds_valid !== 1'b1 || vid_ready !== 1'b0) begin
        n_err++;
        $display("FAIL idle_ctrl cycle %0d: word=%b valid=%b ready=%b, required 1101010100/1/0",
                 k, tmds_word, tmds_valid, vid_ready);
      end
    end
  endtask

  task automatic exit_video(input logic [1:0] c, input string tag);
    ctrl      = c;
    vid_valid = 1'b0;
    tick();
    disp = 0;
    n_cmp++;
    if (tmds_word !== tok(c) || vid_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s: word=%b ready=%b, required word=%b ready=0",
               tag, tmds_word, vid_ready, tok(c));
    end
  endtask

  task automatic test_zero_bytes();
    logic [9:0] e;
    logic [9:0] lit [2];
    lit[0] = 10'b0100000000;
    lit[1] = 10'b1111111111;
    disp = 0;
    enter_video(2'b00, "entry_zero");
    for (int k = 0; k < 2; k++) begin
      drive_byte(8'h00);
      e = exp_q.pop_front();
      n_cmp++;
      if (tmds_word !== e || tmds_word !== lit[k]) begin
        n_err++;
        $display("FAIL zero_byte %0d: word=%b, required %b", k, tmds_word, lit[k]);
      end
    end
    exit_video(2'b00, "exit_zero");
  endtask

  task automatic test_byte_75();
    logic [9:0] e;
    enter_video(2'b01, "entry_75");
    for (int k = 0; k < 3; k++) begin
      drive_byte(8'h75);
      e = exp_q.pop_front();
      n_cmp++;
      if (tmds_word !== e) begin
        n_err++;
        $display("FAIL byte_75 %0d: word=%b, required %b", k, tmds_word, e);
      end
    end
    exit_video(2'b01, "exit_75");
  endtask

  task automatic test_random_stream();
    logic [9:0] e;
    logic [7:0] b;
    enter_video(2'b10, "entry_rand");
    for (int k = 0; k < 40; k++) begin
      b = 8'($urandom_range(255, 0));
      drive_byte(b);
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rand_scoreboard_empty %0d: size=0, required 1", k);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (tmds_word !== e || vid_ready !== 1'b1) begin
          n_err++;
          $display("FAIL rand_byte %0d (0x%h): word=%b ready=%b, required word=%b ready=1",
                   k, b, tmds_word, vid_ready, e);
        end
      end
    end
    exit_video(2'b11, "exit_rand");
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    enter_video(2'b11, "entry_b2b");
    drive_byte(8'h00);
    e = exp_q.pop_front();
    n_cmp++;
    if (tmds_word !== e || tmds_word !== 10'b0100000000) begin
      n_err++;
      $display("FAIL b2b_disparity_cleared: word=%b, required 0100000000", tmds_word);
    end
    exit_video(2'b10, "exit_b2b");
  endtask

  task automatic test_pre_abort();
    ctrl      = 2'b00;
    vid_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) vid_valid = 1'b0;
      tick();
      n_cmp++;
      if (tmds_word !== tok(2'b00) || vid_ready !== 1'b0) begin
        n_err++;
        $display("FAIL pre_abort cycle %0d: word=%b ready=%b, required %b/0",
                 k, tmds_word, vid_ready, tok(2'b00));
      end
    end
    tick();
    enter_video(2'b00, "entry_after_abort");
    exit_video(2'b00, "exit_after_abort");
  endtask

  task automatic test_reset_video();
    logic [9:0] e;
    enter_video(2'b00, "entry_rst");
    drive_byte(8'h00);
    e = exp_q.pop_front();
    n_cmp++;
    if (tmds_word !== e) begin
      n_err++;
      $display("FAIL rst_pre_byte: word=%b, required %b", tmds_word, e);
    end
    rst       = 1'b1;
    vid_valid = 1'b1;
    vid_data  = 8'hFF;
    tick();
    n_cmp++;
    if (tmds_word !== 10'b1101010100 || tmds_valid !== 1'b0 || vid_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_video: word=%b valid=%b ready=%b, required 1101010100/0/0",
               tmds_word, tmds_valid, vid_ready);
    end
    exp_q.delete();
    disp      = 0;
    rst       = 1'b0;
    vid_valid = 1'b0;
    tick();
    enter_video(2'b00, "entry_post_rst");
    drive_byte(8'h00);
    e = exp_q.pop_front();
    n_cmp++;
    if (tmds_word !== e || tmds_word !== 10'b0100000000) begin
      n_err++;
      $display("FAIL rst_disparity_cleared: word=%b, required 0100000000", tmds_word);
    end
    exit_video(2'b00, "exit_post_rst");
  endtask

  initial begin
    test_reset();
    test_zero_bytes();
    test_byte_75();
    test_random_stream();
    test_back_to_back();
    test_pre_abort();
    test_reset_video();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
